// File: rtl/exit_arbiter_if.sv
// Handshake bundle for exit_arbiter.
//   Score stream (s_*): valid/ready beats of class scores, one exit head at a time.
//   Result port (m_*):  valid/ready delivery of the winning class, exit and score.
// Modports:
//   master - the environment: drives score beats and accepts results.
//   slave  - the arbiter: accepts score beats and drives results.
interface exit_arbiter_if #(
  parameter int unsigned NUM_EXITS   = 2,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned BIT_SCORE   = 16
);
  localparam int unsigned EW = (NUM_EXITS > 1) ? $clog2(NUM_EXITS) : 1;
  localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                        s_valid;
  logic                        s_ready;
  logic [EW-1:0]               s_exit;
  logic signed [BIT_SCORE-1:0] s_score;
  logic                        s_last;

  logic                        m_valid;
  logic                        m_ready;
  logic [CW-1:0]               m_class;
  logic [EW-1:0]               m_exit;
  logic signed [BIT_SCORE-1:0] m_score;

  modport master (
    output s_valid, s_exit, s_score, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_exit, m_score
  );

  modport slave (
    input  s_valid, s_exit, s_score, s_last, m_ready,
    output s_ready, m_valid, m_class, m_exit, m_score
  );
endinterface

// File: rtl/exit_arbiter.sv
// Early-termination decision unit for NUM_EXITS exit heads.
// Streams class scores per exit head, tracks a running argmax and compares the winner against
// that head's programmable threshold. Either terminates the inference early or waits for the
// next (deeper) head; the last head always produces the result.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   cfg_we/exit/thr     threshold write port (any state)
//   start               begin a new image (aborts any image in flight)
//   bus (slave)         score stream s_* and result port m_*
//   terminate           high while a result from a non-final head is pending
//   busy                state is not idle
//   err                 sticky protocol error (wrong exit head, wrong beat count)
//
// Optional build macro EXIT_MARGIN_EN: decide on max minus second-highest score instead of
// max, and report that margin (saturated) on m_score.
module exit_arbiter #(
  parameter int unsigned NUM_EXITS   = 2,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned BIT_SCORE   = 16,
  parameter int unsigned BIT_THR     = 16,
  localparam int unsigned EW = (NUM_EXITS > 1) ? $clog2(NUM_EXITS) : 1,
  localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [EW-1:0]             cfg_exit,
  input  logic signed [BIT_THR-1:0] cfg_thr,
  input  logic                      start,
  exit_arbiter_if.slave             bus,
  output logic                      terminate,
  output logic                      busy,
  output logic                      err
);

  // Class counter saturates one past the last class so over-long heads cannot wrap.
  localparam int unsigned NW = $clog2(NUM_CLASSES + 1);
  localparam logic [NW-1:0] LastCnt = NW'(NUM_CLASSES - 1);
  localparam logic [NW-1:0] CntMax  = NW'(NUM_CLASSES);
  localparam logic [EW-1:0] LastExit = EW'(NUM_EXITS - 1);
  localparam logic signed [BIT_THR-1:0] ThrMax = {1'b0, {(BIT_THR-1){1'b1}}};
`ifdef EXIT_MARGIN_EN
  localparam logic signed [BIT_SCORE-1:0] ScoreMax = {1'b0, {(BIT_SCORE-1){1'b1}}};
  localparam logic signed [BIT_SCORE-1:0] ScoreMin = {1'b1, {(BIT_SCORE-1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StCollect, StDecide, StOutput} state_e;

  state_e                      state_q;
  logic [EW-1:0]               cur_exit_q;
  logic [NW-1:0]               cnt_q;
  logic signed [BIT_SCORE-1:0] max_q;
  logic [CW-1:0]               arg_q;
  logic signed [BIT_THR-1:0]   thr_q [NUM_EXITS];
  logic                        err_q;
  logic                        m_valid_q;
  logic [CW-1:0]               m_class_q;
  logic [EW-1:0]               m_exit_q;
  logic signed [BIT_SCORE-1:0] m_score_q;
  logic                        terminate_q;
`ifdef EXIT_MARGIN_EN
  logic signed [BIT_SCORE-1:0] second_q;
`endif

  // Decision datapath, evaluated while in StDecide.
  logic signed [BIT_THR-1:0]   thr_sel;
  logic signed [BIT_SCORE:0]   thr_ext;
  logic signed [BIT_SCORE:0]   metric;
  logic signed [BIT_SCORE-1:0] result_score;
  logic                        last_exit;
  logic                        exit_take;
  logic                        take_new;

  always_comb begin
    thr_sel   = thr_q[cur_exit_q];
    thr_ext   = (BIT_SCORE+1)'(thr_sel);
    last_exit = (cur_exit_q == LastExit);
`ifdef EXIT_MARGIN_EN
    // Second never exceeds max, so the BIT_SCORE+1 difference is non-negative.
    metric = (BIT_SCORE+1)'(max_q) - (BIT_SCORE+1)'(second_q);
    if (metric > (BIT_SCORE+1)'(ScoreMax)) begin
      result_score = ScoreMax;
    end else begin
      result_score = metric[BIT_SCORE-1:0];
    end
`else
    metric       = (BIT_SCORE+1)'(max_q);
    result_score = max_q;
`endif
    exit_take = (metric > thr_ext) || last_exit;
    // Strict compare: ties keep the lower class index.
    take_new  = (cnt_q == '0) || (bus.s_score > max_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_exit_q  <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      arg_q       <= '0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      m_exit_q    <= '0;
      m_score_q   <= '0;
      terminate_q <= 1'b0;
`ifdef EXIT_MARGIN_EN
      second_q    <= ScoreMin;
`endif
      for (int i = 0; i < int'(NUM_EXITS); i++) begin
        thr_q[i] <= ThrMax;
      end
    end else begin
      if (cfg_we && (32'(cfg_exit) < NUM_EXITS)) begin
        thr_q[cfg_exit] <= cfg_thr;
      end

      if (start) begin
        // New image, also used to abort one in flight; wins over m_ready and s_last.
        state_q     <= StCollect;
        cur_exit_q  <= '0;
        cnt_q       <= '0;
        max_q       <= '0;
        arg_q       <= '0;
        err_q       <= 1'b0;
        m_valid_q   <= 1'b0;
        terminate_q <= 1'b0;
`ifdef EXIT_MARGIN_EN
        second_q    <= ScoreMin;
`endif
      end else begin
        case (state_q)
          StIdle: ;
          StCollect: begin
            if (bus.s_valid) begin
              if (bus.s_exit != cur_exit_q) begin
                err_q <= 1'b1;
              end else begin
                if (take_new) begin
                  max_q <= bus.s_score;
                  arg_q <= cnt_q[CW-1:0];
                end
`ifdef EXIT_MARGIN_EN
                if (cnt_q != '0) begin
                  if (bus.s_score > max_q) begin
                    second_q <= max_q;
                  end else if (bus.s_score > second_q) begin
                    second_q <= bus.s_score;
                  end
                end
`endif
                if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + 1'b1;
                end
                if (bus.s_last) begin
                  state_q <= StDecide;
                  if (cnt_q != LastCnt) begin
                    err_q <= 1'b1;
                  end
                end
              end
            end
          end
          StDecide: begin
            if (exit_take) begin
              state_q     <= StOutput;
              m_valid_q   <= 1'b1;
              m_class_q   <= arg_q;
              m_exit_q    <= cur_exit_q;
              m_score_q   <= result_score;
              terminate_q <= !last_exit;
            end else begin
              state_q    <= StCollect;
              cur_exit_q <= cur_exit_q + 1'b1;
              cnt_q      <= '0;
              max_q      <= '0;
`ifdef EXIT_MARGIN_EN
              second_q   <= ScoreMin;
`endif
            end
          end
          StOutput: begin
            if (bus.m_ready) begin
              state_q     <= StIdle;
              m_valid_q   <= 1'b0;
              terminate_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.s_ready = (state_q == StCollect);
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign bus.m_exit  = m_exit_q;
  assign bus.m_score = m_score_q;
  assign terminate   = terminate_q;
  assign busy        = (state_q != StIdle);
  assign err         = err_q;

endmodule
